// File: rtl/difftest_commit_buffer.sv
// Four-entry commit record FIFO feeding a difftest trace port, with a shadow GPR file updated on pop.
// Optional retire counter output enabled by defining DIFFTEST_RETIRE_CNT_EN.
module difftest_commit_buffer (
   input  logic        clock,
   input  logic        reset,
   input  logic        commit_valid,
   output logic        commit_ready,
   input  logic [63:0] commit_pc,
   input  logic [31:0] commit_inst,
   input  logic        commit_wen,
   input  logic [4:0]  commit_rd,
   input  logic [63:0] commit_wdata,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [63:0] trace_pc,
   output logic [31:0] trace_inst,
   output logic [63:0] retired_pc,
   input  logic [4:0]  rd_idx,
`ifdef DIFFTEST_RETIRE_CNT_EN
   output logic [63:0] retire_cnt,
`endif
   output logic [63:0] rd_data
);

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   logic [63:0] pc_q    [4];
   logic [63:0] pc_d    [4];
   logic [31:0] inst_q  [4];
   logic [31:0] inst_d  [4];
   logic        wen_q   [4];
   logic        wen_d   [4];
   logic [4:0]  rd_q    [4];
   logic [4:0]  rd_d    [4];
   logic [63:0] wdata_q [4];
   logic [63:0] wdata_d [4];
   logic [63:0] gpr_q   [32];
   logic [63:0] gpr_d   [32];

   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic [63:0] retired_pc_q, retired_pc_d;
`ifdef DIFFTEST_RETIRE_CNT_EN
   logic [63:0] retire_cnt_q, retire_cnt_d;
`endif

   logic push;
   logic pop;

   // Ready is a function of stored occupancy only, so a pop never frees a slot in the same cycle.
   assign commit_ready = (count_q != 3'd4);
   assign trace_valid  = (count_q != 3'd0);
   assign push         = commit_valid && commit_ready;
   assign pop          = trace_valid && trace_ready;

   assign trace_pc   = pc_q[rd_ptr_q];
   assign trace_inst = inst_q[rd_ptr_q];
   assign retired_pc = retired_pc_q;
   assign rd_data    = (rd_idx == 5'd0) ? 64'd0 : gpr_q[rd_idx];
`ifdef DIFFTEST_RETIRE_CNT_EN
   assign retire_cnt = retire_cnt_q;
`endif

   always_comb begin
      pc_d         = pc_q;
      inst_d       = inst_q;
      wen_d        = wen_q;
      rd_d         = rd_q;
      wdata_d      = wdata_q;
      gpr_d        = gpr_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      retired_pc_d = retired_pc_q;
`ifdef DIFFTEST_RETIRE_CNT_EN
      retire_cnt_d = retire_cnt_q;
`endif

      if (push) begin
         pc_d[wr_ptr_q]    = commit_pc;
         inst_d[wr_ptr_q]  = commit_inst;
         wen_d[wr_ptr_q]   = commit_wen;
         rd_d[wr_ptr_q]    = commit_rd;
         wdata_d[wr_ptr_q] = commit_wdata;
         wr_ptr_d          = wr_ptr_q + 2'd1;
      end

      // x0 is never written, which keeps gpr_q[0] at its reset value of zero.
      if (pop) begin
         rd_ptr_d     = rd_ptr_q + 2'd1;
         retired_pc_d = pc_q[rd_ptr_q];
         if (wen_q[rd_ptr_q] && (rd_q[rd_ptr_q] != 5'd0)) begin
            gpr_d[rd_q[rd_ptr_q]] = wdata_q[rd_ptr_q];
         end
`ifdef DIFFTEST_RETIRE_CNT_EN
         retire_cnt_d = retire_cnt_q + 64'd1;
`endif
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            pc_q[i]    <= '0;
            inst_q[i]  <= '0;
            wen_q[i]   <= 1'b0;
            rd_q[i]    <= '0;
            wdata_q[i] <= '0;
         end
         for (int i = 0; i < 32; i++) begin
            gpr_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         retired_pc_q <= RESET_PC;
`ifdef DIFFTEST_RETIRE_CNT_EN
         retire_cnt_q <= '0;
`endif
      end else begin
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         wen_q        <= wen_d;
         rd_q         <= rd_d;
         wdata_q      <= wdata_d;
         gpr_q        <= gpr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         retired_pc_q <= retired_pc_d;
`ifdef DIFFTEST_RETIRE_CNT_EN
         retire_cnt_q <= retire_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_difftest_commit_buffer.sv
// Directed self-checking bench for difftest_commit_buffer: single record, fill, full-with-pop,
// simultaneous push/pop, pointer wrap, x0 write and mid-operation reset.
`timescale 1ns/1ps
module tb_difftest_commit_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        commit_valid;
   logic        commit_ready;
   logic [63:0] commit_pc;
   logic [31:0] commit_inst;
   logic        commit_wen;
   logic [4:0]  commit_rd;
   logic [63:0] commit_wdata;
   logic        trace_valid;
   logic        trace_ready;
   logic [63:0] trace_pc;
   logic [31:0] trace_inst;
   logic [63:0] retired_pc;
   logic [4:0]  rd_idx;
   logic [63:0] rd_data;
`ifdef DIFFTEST_RETIRE_CNT_EN
   logic [63:0] retire_cnt;
   logic [63:0] cntBefore;
`endif

   int testCount = 0;
   int failCount = 0;

   always #5 clock = ~clock;

   difftest_commit_buffer dut (
      .clock        (clock),
      .reset        (reset),
      .commit_valid (commit_valid),
      .commit_ready (commit_ready),
      .commit_pc    (commit_pc),
      .commit_inst  (commit_inst),
      .commit_wen   (commit_wen),
      .commit_rd    (commit_rd),
      .commit_wdata (commit_wdata),
      .trace_valid  (trace_valid),
      .trace_ready  (trace_ready),
      .trace_pc     (trace_pc),
      .trace_inst   (trace_inst),
      .retired_pc   (retired_pc),
      .rd_idx       (rd_idx),
`ifdef DIFFTEST_RETIRE_CNT_EN
      .retire_cnt   (retire_cnt),
`endif
      .rd_data      (rd_data)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Instruction word is derived from the pc so trace_inst can be predicted by hand.
   task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic wen,
                                input logic [4:0] rd, input logic [63:0] wdata, input logic tready);
      commit_valid = v;
      commit_pc    = pc;
      commit_inst  = pc[31:0] ^ 32'h0000_0013;
      commit_wen   = wen;
      commit_rd    = rd;
      commit_wdata = wdata;
      trace_ready  = tready;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic readGpr(input logic [4:0] idx, output logic [63:0] val);
      rd_idx = idx;
      #1;
      val = rd_data;
   endtask

   logic [63:0] val;
   logic [63:0] acc;
   logic [63:0] expQ[$];
   logic [63:0] lastPc;
   logic [63:0] nextPc;
   int          pushed;
   int          popped;
   logic        v;
   logic        r;
   logic        doPop;
   logic        doPush;

   initial begin
      reset  = 1'b1;
      rd_idx = 5'd0;
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
      #12;
      checkOutput("rst_commit_ready", commit_ready, 1);
      checkOutput("rst_trace_valid", trace_valid, 0);
      checkOutput("rst_retired_pc", retired_pc, 64'h8000_0000);
      readGpr(5'd5, val);
      checkOutput("rst_gpr5", val, 0);
`ifdef DIFFTEST_RETIRE_CNT_EN
      checkOutput("rst_retire_cnt", retire_cnt, 0);
`endif
      @(negedge clock);
      reset = 1'b0;
      tick;

      // Single record: visible one cycle after push, shadow update on pop.
      applyStimulus(1'b1, 64'h8000_0000, 1'b1, 5'd5, 64'h1234, 1'b1);
      #1;
      checkOutput("single_no_bypass", trace_valid, 0);
      tick;
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
      checkOutput("single_valid", trace_valid, 1);
      checkOutput("single_pc", trace_pc, 64'h8000_0000);
      checkOutput("single_inst", trace_inst, 64'h8000_0013);
      tick;
      checkOutput("single_empty", trace_valid, 0);
      checkOutput("single_retired", retired_pc, 64'h8000_0000);
      readGpr(5'd5, val);
      checkOutput("single_gpr5", val, 64'h1234);

      // x0 write is dropped.
      applyStimulus(1'b1, 64'h8000_0004, 1'b1, 5'd0, 64'hFFFF, 1'b1);
      tick;
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
      tick;
      checkOutput("x0_retired", retired_pc, 64'h8000_0004);
      readGpr(5'd0, val);
      checkOutput("x0_reads_zero", val, 0);

      // wen=0 record leaves the shadow file alone.
      applyStimulus(1'b1, 64'h8000_0008, 1'b0, 5'd5, 64'hDEAD, 1'b1);
      tick;
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
      tick;
      readGpr(5'd5, val);
      checkOutput("nowen_gpr5", val, 64'h1234);

      // Fill: five back-to-back pushes, only four accepted.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 64'h1000 + 64'(i) * 4, 1'b1, 5'(i + 1), 64'h100 + 64'(i), 1'b0);
         #1;
         checkOutput($sformatf("fill_ready_%0d", i), commit_ready, (i < 4) ? 1 : 0);
         tick;
      end
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
      checkOutput("fill_full_ready", commit_ready, 0);
      for (int j = 0; j < 4; j++) begin
         checkOutput($sformatf("fill_pop_pc_%0d", j), trace_pc, 64'h1000 + 64'(j) * 4);
         tick;
      end
      checkOutput("fill_drained", trace_valid, 0);
      readGpr(5'd4, val);
      checkOutput("fill_gpr4", val, 64'h103);
      readGpr(5'd5, val);
      checkOutput("fill_gpr5_refused", val, 64'h1234);

      // Full with a same-cycle pop still refuses the push.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'h2000 + 64'(i) * 4, 1'b0, 5'd0, 64'd0, 1'b0);
         tick;
      end
      applyStimulus(1'b1, 64'h2010, 1'b0, 5'd0, 64'd0, 1'b1);
      #1;
      checkOutput("full_pop_ready", commit_ready, 0);
      tick;
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
      checkOutput("full_pop_head", trace_pc, 64'h2004);
      checkOutput("full_pop_ready_after", commit_ready, 1);
      for (int j = 1; j < 4; j++) begin
         checkOutput($sformatf("full_drain_pc_%0d", j), trace_pc, 64'h2000 + 64'(j) * 4);
         tick;
      end
      checkOutput("full_refused_empty", trace_valid, 0);

      // Simultaneous push and pop at count=2 keeps count at 2.
      applyStimulus(1'b1, 64'h3000, 1'b0, 5'd0, 64'd0, 1'b0);
      tick;
      applyStimulus(1'b1, 64'h3004, 1'b0, 5'd0, 64'd0, 1'b0);
      tick;
      applyStimulus(1'b1, 64'h3008, 1'b1, 5'd7, 64'h77, 1'b1);
      tick;
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1);
      checkOutput("sim_retired", retired_pc, 64'h3000);
      checkOutput("sim_head", trace_pc, 64'h3004);
      tick;
      checkOutput("sim_head2", trace_pc, 64'h3008);
      tick;
      checkOutput("sim_count2_empty", trace_valid, 0);
      readGpr(5'd7, val);
      checkOutput("sim_gpr7", val, 64'h77);

      // Wrap: ten records with trace_ready toggling, compared against an in-order queue.
`ifdef DIFFTEST_RETIRE_CNT_EN
      cntBefore = retire_cnt;
`endif
      pushed = 0;
      popped = 0;
      lastPc = 64'd0;
      for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
         v      = (pushed < 10);
         r      = cyc[0];
         nextPc = 64'h5000 + 64'(pushed) * 4;
         applyStimulus(v, nextPc, 1'b0, 5'd0, 64'd0, r);
         #1;
         checkOutput($sformatf("wrap_valid_%0d", cyc), trace_valid, (expQ.size() != 0) ? 1 : 0);
         checkOutput($sformatf("wrap_ready_%0d", cyc), commit_ready, (expQ.size() != 4) ? 1 : 0);
         if (r && expQ.size() != 0)
            checkOutput($sformatf("wrap_pc_%0d", cyc), trace_pc, expQ[0]);
         doPop  = r && (expQ.size() != 0);
         doPush = v && (expQ.size() != 4);
         if (doPop) begin
            lastPc = expQ.pop_front();
            popped++;
         end
         if (doPush) begin
            expQ.push_back(nextPc);
            pushed++;
         end
         tick;
      end
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
      checkOutput("wrap_retired", retired_pc, 64'h5024);
      checkOutput("wrap_empty", trace_valid, 0);
`ifdef DIFFTEST_RETIRE_CNT_EN
      checkOutput("wrap_retire_cnt", retire_cnt, cntBefore + 64'd10);
`endif

      // Mid-operation reset with three records buffered.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 64'h4000 + 64'(i) * 4, 1'b1, 5'(i + 10), 64'hABC, 1'b0);
         tick;
      end
      checkOutput("mid_pre_valid", trace_valid, 1);
      applyStimulus(1'b1, 64'h4100, 1'b1, 5'd12, 64'h55, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_valid", trace_valid, 0);
      checkOutput("mid_ready", commit_ready, 1);
      checkOutput("mid_retired", retired_pc, 64'h8000_0000);
      tick;
      tick;
      checkOutput("mid_hold_valid", trace_valid, 0);
      applyStimulus(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
      acc = 64'd0;
      for (int g = 0; g < 32; g++) begin
         readGpr(5'(g), val);
         acc = acc | val;
      end
      checkOutput("mid_gprs_zero", acc, 0);
`ifdef DIFFTEST_RETIRE_CNT_EN
      checkOutput("mid_retire_cnt", retire_cnt, 0);
`endif
      @(negedge clock);
      reset = 1'b0;
      tick;
      checkOutput("post_rst_valid", trace_valid, 0);
      checkOutput("post_rst_retired", retired_pc, 64'h8000_0000);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/difftest_commit_buffer.md
DIFFTEST_COMMIT_BUFFER -- requirements
Module: difftest_commit_buffer

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: commit_valid  input  1  retiring instruction record presented.
REQ-004 SHALL have port: commit_ready  output  1  buffer accepts a record this cycle.
REQ-005 SHALL have port: commit_pc  input  64  PC of the retiring instruction.
REQ-006 SHALL have port: commit_inst  input  32  instruction word.
REQ-007 SHALL have port: commit_wen  input  1  instruction writes a GPR.
REQ-008 SHALL have port: commit_rd  input  5  destination GPR index.
REQ-009 SHALL have port: commit_wdata  input  64  destination write value.
REQ-010 SHALL have port: trace_valid  output  1  head record available to the trace consumer.
REQ-011 SHALL have port: trace_ready  input  1  trace consumer takes the head record.
REQ-012 SHALL have port: trace_pc / trace_inst  output  64 / 32  head record PC and instruction.
REQ-013 SHALL have port: retired_pc  output  64  PC of the most recently popped record.
REQ-014 SHALL have port: rd_idx  input  5  shadow GPR read index.
REQ-015 SHALL have port: rd_data  output  64  combinational shadow GPR value at rd_idx.

Function
REQ-016 SHALL hold a 4-entry FIFO of {pc, inst, wen, rd, wdata} records with 2-bit read/write pointers and a 3-bit occupancy count (0..4).
REQ-017 SHALL push when commit_valid && commit_ready; commit_ready = (count != 4).
REQ-018 SHALL pop when trace_valid && trace_ready; trace_valid = (count != 0).
REQ-019 SHALL drive trace_pc/trace_inst from the head entry; a pushed record appears on trace_valid in the cycle after its push (1-cycle latency, no same-cycle bypass).
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers; when full, commit_ready = 0 even if a pop occurs in the same cycle.
REQ-021 SHALL wrap pointers modulo 4 (3 -> 0) without loss or duplication.
REQ-022 SHALL, on pop, write wdata to shadow GPR[rd] if wen && rd != 0, and load retired_pc with the popped pc, in the same clock edge.
REQ-023 SHALL hold shadow GPR[0] at 0 permanently; rd_data for rd_idx = 0 SHALL read 0.
REQ-024 SHALL ignore commit_* contents when commit_valid = 0, and SHALL leave state unchanged on a pop attempt when empty or a push attempt when full.

Reset
REQ-025 SHALL, on reset assertion (asynchronously), clear pointers and count, force trace_valid = 0, commit_ready = 1, retired_pc = 0x0000_0000_8000_0000, and all shadow GPRs = 0.
REQ-026 SHALL discard all buffered records on reset mid-operation; no pops or shadow writes occur while reset is high.

Configuration
REQ-027 SHALL, with DIFFTEST_RETIRE_CNT_EN defined, add output retire_cnt (64) counting pops, reset to 0, incremented by 1 per pop, wrapping at 2^64.
REQ-028 SHALL, without DIFFTEST_RETIRE_CNT_EN, omit the retire_cnt port and counter entirely; all other behaviour identical.

Verification
REQ-029 Single record: push {pc=0x80000000, wen=1, rd=5, wdata=0x1234}, trace_ready=1 -> trace_valid high next cycle; after pop, rd_idx=5 gives 0x1234, retired_pc=0x80000000.
REQ-030 Fill: 5 back-to-back pushes, trace_ready=0 -> first 4 accepted, commit_ready=0 on 5th; pops return pcs in push order.
REQ-031 Wrap: 10 pushes/pops with trace_ready toggling -> pointers wrap, all 10 pcs popped in order, none duplicated.
REQ-032 x0 write: pop {wen=1, rd=0, wdata=0xFFFF} -> rd_idx=0 reads 0.
REQ-033 Simultaneous push+pop at count=2 -> count stays 2, both records correct; at count=4 push is refused.
REQ-034 Reset mid-operation with count=3 -> trace_valid=0 immediately, retired_pc=0x80000000, all shadow GPRs 0; with DIFFTEST_RETIRE_CNT_EN retire_cnt=0.
